// File: rtl/switch_input_controller.sv
// Switch/button front end: 2-flop synchronizers, per-bit debounce counters,
// sticky button-press flags with clear-on-read, and a 1-cycle CPU read port.
module switch_input_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SW_WIDTH        = 6,
   parameter int unsigned BTN_WIDTH       = 4
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [SW_WIDTH-1:0]  Switch,
   input  logic [BTN_WIDTH-1:0] Button,
   input  logic                 ReadReq,
   input  logic                 ReadAddr,
   output logic [23:0]          ReadData,
   output logic                 ReadValid,
   output logic                 Irq
);

   localparam int unsigned NBITS = SW_WIDTH + BTN_WIDTH;
   localparam int unsigned CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NBITS-1:0]     raw;
   logic [NBITS-1:0]     sync1_q, sync2_q;
   logic [NBITS-1:0]     deb_q, deb_d;
   logic [CW-1:0]        cnt_q [NBITS];
   logic [CW-1:0]        cnt_d [NBITS];
   logic [BTN_WIDTH-1:0] flag_q, flag_d;
   logic [BTN_WIDTH-1:0] btn_rise, flag_clr;
   logic [SW_WIDTH-1:0]  sw_deb;
   logic [23:0]          read_data_q, read_data_d;
   logic                 read_valid_q, irq_q;

   assign raw    = {Button, Switch};
   assign sw_deb = deb_q[SW_WIDTH-1:0];

   // A counter only runs while the synchronized level disagrees with the
   // debounced level, so any glitch back to the old level restarts the count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < NBITS; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // New presses are ORed in after the clear so a coincident event survives the read.
   always_comb begin
      btn_rise = deb_d[NBITS-1:SW_WIDTH] & ~deb_q[NBITS-1:SW_WIDTH];
      flag_clr = (ReadReq && ReadAddr) ? flag_q : '0;
      flag_d   = (flag_q & ~flag_clr) | btn_rise;
   end

   always_comb begin
      read_data_d = read_data_q;
      if (ReadReq) begin
         read_data_d = ReadAddr ? 24'(flag_q) : 24'(sw_deb);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         for (int unsigned i = 0; i < NBITS; i++) cnt_q[i] <= '0;
         flag_q       <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         cnt_q        <= cnt_d;
         flag_q       <= flag_d;
         read_data_q  <= read_data_d;
         read_valid_q <= ReadReq;
         irq_q        <= |flag_q;
      end
   end

   assign ReadData  = read_data_q;
   assign ReadValid = read_valid_q;
   assign Irq       = irq_q;

endmodule

// File: tb/tb_switch_input_controller.sv
// Scoreboard bench for switch_input_controller with DEBOUNCE_CYCLES=4.
module tb_switch_input_controller;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [5:0]  Switch;
   logic [3:0]  Button;
   logic        ReadReq;
   logic        ReadAddr;
   logic [23:0] ReadData;
   logic        ReadValid;
   logic        Irq;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] exp_q [$];
   logic [23:0] last_exp = '0;
   logic        mon_en   = 1'b0;

   switch_input_controller #(
      .DEBOUNCE_CYCLES(4),
      .SW_WIDTH       (6),
      .BTN_WIDTH      (4)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Switch   (Switch),
      .Button   (Button),
      .ReadReq  (ReadReq),
      .ReadAddr (ReadAddr),
      .ReadData (ReadData),
      .ReadValid(ReadValid),
      .Irq      (Irq)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one edge; ReadValid must mirror whether a read was issued before it.
   task automatic step();
      logic was_req;
      was_req = ReadReq & Reset;
      @(posedge Clock);
      #1;
      check("read_valid_latency", 24'(ReadValid), 24'(was_req));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic issue(input logic addr, input logic [23:0] exp);
      ReadReq  = 1'b1;
      ReadAddr = addr;
      exp_q.push_back(exp);
   endtask

   always @(negedge Clock) begin
      if (mon_en) begin
         if (ReadValid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", ReadData, 24'hFFFFFF ^ ReadData);
            end else begin
               last_exp = exp_q.pop_front();
               check("read_data", ReadData, last_exp);
            end
         end else begin
            check("read_data_hold", ReadData, last_exp);
         end
      end
   end

   initial begin
      Reset = 1'b0; Switch = '0; Button = '0; ReadReq = 1'b0; ReadAddr = 1'b0;
      @(posedge Clock); @(posedge Clock); #1;
      check("reset_data", ReadData, 24'h0);
      check("reset_valid", 24'(ReadValid), 24'h0);
      check("reset_irq", 24'(Irq), 24'h0);
      Reset  = 1'b1;
      mon_en = 1'b1;
      steps(3);

      // Switch change with a read every cycle: new word first returned by the read at edge 7
      Switch = 6'b101101;
      for (int k = 1; k <= 9; k++) begin
         issue(1'b0, (k >= 7) ? 24'h00002D : 24'h0);
         step();
      end
      ReadReq = 1'b0;
      step();

      // 3-cycle pulse on button 0 must not debounce
      Button = 4'b0001;
      steps(3);
      Button = 4'b0000;
      steps(6);
      check("pulse_no_irq", 24'(Irq), 24'h0);
      issue(1'b1, 24'h0);
      step();
      ReadReq = 1'b0;

      // Steady press: flag at edge 6, Irq one edge later
      Button = 4'b0001;
      steps(6);
      check("irq_before_flag_seen", 24'(Irq), 24'h0);
      step();
      check("irq_after_press", 24'(Irq), 24'h1);
      Button = 4'b0101;
      steps(7);
      issue(1'b1, 24'h000005);
      step();
      ReadReq = 1'b0;
      check("irq_same_cycle_as_clear", 24'(Irq), 24'h1);
      step();
      check("irq_after_clear", 24'(Irq), 24'h0);
      issue(1'b1, 24'h0);
      step();
      ReadReq = 1'b0;

      // Release: falling edges set no flags
      Button = 4'b0000;
      steps(8);
      check("release_no_irq", 24'(Irq), 24'h0);

      // Button 2 rise lands on the same edge as a clearing read of flag 0
      Button = 4'b0001;
      steps(7);
      Button = 4'b0101;
      steps(5);
      issue(1'b1, 24'h000001);
      step();
      ReadReq = 1'b0;
      check("irq_coincident", 24'(Irq), 24'h1);
      step();
      check("irq_held_by_new_event", 24'(Irq), 24'h1);
      issue(1'b1, 24'h000004);
      step();
      issue(1'b1, 24'h0);
      step();
      ReadReq = 1'b0;
      step();

      // Back-to-back reads: switch word then flag word
      issue(1'b0, 24'h00002D);
      step();
      issue(1'b1, 24'h0);
      step();
      ReadReq = 1'b0;
      step();

      // Reset mid-debounce with a pending read
      Button = 4'b1000;
      steps(7);
      check("irq_btn3", 24'(Irq), 24'h1);
      issue(1'b0, 24'h00002D);
      step();
      ReadReq = 1'b0;
      Switch = 6'b010010;
      Button = 4'b0010;
      steps(3);
      ReadReq  = 1'b1;
      ReadAddr = 1'b0;
      #2;
      Reset    = 1'b0;
      last_exp = '0;
      #1;
      check("async_reset_data", ReadData, 24'h0);
      check("async_reset_valid", 24'(ReadValid), 24'h0);
      check("async_reset_irq", 24'(Irq), 24'h0);
      ReadReq = 1'b0;
      steps(2);
      Reset = 1'b1;
      steps(6);
      check("irq_post_reset_early", 24'(Irq), 24'h0);
      step();
      check("irq_post_reset", 24'(Irq), 24'h1);
      issue(1'b1, 24'h000002);
      step();
      issue(1'b0, 24'h000012);
      step();
      ReadReq = 1'b0;
      steps(2);
      check("scoreboard_drained", 24'(exp_q.size()), 24'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
